// File: rtl/palindrome_pkg.sv
// Shared definitions for the palindrome checker front end: widths, FSM encoding
// and the last register-file address.
package palindrome_pkg;

  localparam int WIDTH        = 32;
  localparam int ADDR_W       = 5;
  localparam int RF_LAST_ADDR = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/palindrome_loader.sv
// Streams a packet into consecutive register-file entries, runs the palindrome
// checker over the stored range and reports the verdict as a one-cycle beat.
module palindrome_loader
  import palindrome_pkg::*;
#(
  parameter int WIDTH  = palindrome_pkg::WIDTH,
  parameter int ADDR_W = palindrome_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]  rf_wr_data,
  output logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] ending,
  output logic              go,
  input  logic              done_in,
  input  logic              palindrome_in,
  output logic              result_valid,
  output logic              result_palindrome,
  output logic [ADDR_W:0]   result_len,
  output logic              overflow_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, ending_q, ptr_q;
  logic [ADDR_W-1:0]   ptr_nxt_s;
  logic [ADDR_W:0]     count_q;
  logic                verdict_q, overflow_q;
  logic                accept_s, at_end_s, overflow_s;

  assign ptr_nxt_s  = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  // ptr_q holds the address of the last stored word, so a further beat would fall off the end.
  assign at_end_s   = (ptr_q == ADDR_W'(RF_LAST_ADDR));
  assign accept_s   = in_valid & in_ready;
  assign overflow_s = accept_s & (state_q == ST_LOAD) & at_end_s;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = in_last ? ST_RUN : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (overflow_s) begin
          state_d = ST_REPORT;
        end else if (accept_s && in_last) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (done_in) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode; in_ready is masked while reset is held so no write can slip through.
  always_comb begin
    in_ready          = reset & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    go                = (state_q == ST_RUN);
    result_valid      = (state_q == ST_REPORT);
    result_palindrome = (state_q == ST_REPORT) & verdict_q;
    overflow_err      = (state_q == ST_REPORT) & overflow_q;
    result_len        = count_q;
    base              = base_q;
    ending            = ending_q;
    rf_wr_en          = accept_s & ~overflow_s;
    rf_wr_data        = in_data;
    if (state_q == ST_IDLE) begin
      rf_wr_addr = start_addr;
    end else begin
      rf_wr_addr = ptr_nxt_s;
    end
  end

  // Packet bookkeeping: range, word count and captured verdict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q     <= '0;
      ending_q   <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      verdict_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            base_q     <= start_addr;
            ptr_q      <= start_addr;
            count_q    <= {{ADDR_W{1'b0}}, 1'b1};
            verdict_q  <= 1'b0;
            overflow_q <= 1'b0;
            if (in_last) begin
              ending_q <= start_addr;
            end
          end
        end
        ST_LOAD: begin
          if (overflow_s) begin
            overflow_q <= 1'b1;
            verdict_q  <= 1'b0;
          end else if (accept_s) begin
            ptr_q   <= ptr_nxt_s;
            count_q <= count_q + {{ADDR_W{1'b0}}, 1'b1};
            if (in_last) begin
              ending_q <= ptr_nxt_s;
            end
          end
        end
        ST_RUN: begin
          if (done_in) begin
            verdict_q <= palindrome_in;
          end
        end
        default: begin
          verdict_q <= verdict_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palindrome_loader.sv
// Directed bench for palindrome_loader: a bench-side register file captures the
// write port and a small responder plays the role of palindrome_control.
module tb_palindrome_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  start_addr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  base;
  logic [4:0]  ending;
  logic        go;
  logic        done_in;
  logic        palindrome_in;
  logic        result_valid;
  logic        result_palindrome;
  logic [5:0]  result_len;
  logic        overflow_err;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  logic [31:0] mem [32];
  logic [31:0] pk [8];

  palindrome_loader dut (
    .clock(clock), .reset(reset), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .base(base), .ending(ending), .go(go), .done_in(done_in),
    .palindrome_in(palindrome_in), .result_valid(result_valid),
    .result_palindrome(result_palindrome), .result_len(result_len),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  // Bench register file fed by the loader's write port.
  always @(posedge clock) begin
    if (rf_wr_en) begin
      mem[rf_wr_addr] <= rf_wr_data;
      wr_count        <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream one packet, answer go like the checker would, then check the result beat.
  task automatic run_pkt(input string tag, input logic [4:0] sa, input int n,
                         input logic [31:0] w [8], input bit gaps, input logic exp_pal);
    logic       pal;
    logic [4:0] e;
    logic [4:0] lo;
    logic [4:0] hi;
    e = sa + 5'(n - 1);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 32'h0;
        #1 check({tag, "_gap_wr"}, rf_wr_en, 1'b0);
      end
      @(negedge clock);
      start_addr = sa;
      in_valid   = 1'b1;
      in_data    = w[i];
      in_last    = (i == n - 1);
      #1;
      check({tag, "_rdy"}, in_ready, 1'b1);
      check({tag, "_wr_en"}, rf_wr_en, 1'b1);
      check({tag, "_wr_addr"}, rf_wr_addr, 5'(sa + 5'(i)));
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check({tag, "_go"}, go, 1'b1);
    check({tag, "_base"}, base, sa);
    check({tag, "_ending"}, ending, e);
    check({tag, "_rdy_run"}, in_ready, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    check({tag, "_go_hold"}, go, 1'b1);
    check({tag, "_rv_run"}, result_valid, 1'b0);
    check({tag, "_mem_first"}, mem[sa], w[0]);
    check({tag, "_mem_last"}, mem[e], w[n - 1]);
    pal = 1'b1;
    for (int i = 0; i < n; i++) begin
      lo = sa + 5'(i);
      hi = e - 5'(i);
      if (mem[lo] !== mem[hi]) pal = 1'b0;
    end
    done_in       = 1'b1;
    palindrome_in = pal;
    @(negedge clock);
    done_in       = 1'b0;
    palindrome_in = 1'b0;
    #1;
    check({tag, "_rv"}, result_valid, 1'b1);
    check({tag, "_pal"}, result_palindrome, exp_pal);
    check({tag, "_len"}, result_len, 6'(n));
    check({tag, "_ovf"}, overflow_err, 1'b0);
    check({tag, "_go_off"}, go, 1'b0);
    check({tag, "_rdy_rep"}, in_ready, 1'b0);
    @(negedge clock);
    #1;
    check({tag, "_rv_one"}, result_valid, 1'b0);
    check({tag, "_rdy_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int wr0;
    reset         = 1'b0;
    start_addr    = 5'd0;
    in_valid      = 1'b0;
    in_data       = 32'h0;
    in_last       = 1'b0;
    done_in       = 1'b0;
    palindrome_in = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_go", go, 1'b0);
    check("rst_rv", result_valid, 1'b0);
    check("rst_base", base, 5'd0);
    check("rst_ending", ending, 5'd0);
    check("rst_len", result_len, 6'd0);
    check("rst_ovf", overflow_err, 1'b0);
    check("rst_wr_en", rf_wr_en, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("rst_rel_rdy", in_ready, 1'b1);

    pk = '{32'h12344321, 32'h0, 32'h0, 32'h12344321, 32'h0, 32'h0, 32'h0, 32'h0};
    run_pkt("even", 5'd11, 4, pk, 1'b0, 1'b1);
    pk = '{32'hCAFEBABE, 32'hFFFFFFFF, 32'h0B3D1E55, 32'hFFFFFFFF, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0};
    run_pkt("odd", 5'd2, 5, pk, 1'b0, 1'b1);
    run_pkt("bubbles", 5'd20, 5, pk, 1'b1, 1'b1);
    pk = '{32'h33333333, 32'hC001D0D3, 32'hFFFFFFFF, 32'hBAB3D0D3, 32'h33333333, 32'h0, 32'h0, 32'h0};
    run_pkt("fail", 5'd7, 5, pk, 1'b0, 1'b0);
    pk = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_pkt("single", 5'd31, 1, pk, 1'b0, 1'b1);
    pk = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h0};
    run_pkt("last31", 5'd28, 4, pk, 1'b0, 1'b1);

    // Overflow: third non-last beat from address 30 runs off the register file.
    wr0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start_addr = 5'd30;
      in_valid   = 1'b1;
      in_data    = 32'h11111111 * (i + 1);
      in_last    = 1'b0;
      #1;
      check("ovf_rdy", in_ready, 1'b1);
      check("ovf_wr_en", rf_wr_en, (i < 2) ? 1'b1 : 1'b0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("ovf_rv", result_valid, 1'b1);
    check("ovf_err", overflow_err, 1'b1);
    check("ovf_len", result_len, 6'd2);
    check("ovf_pal", result_palindrome, 1'b0);
    check("ovf_go", go, 1'b0);
    check("ovf_writes", 64'(wr_count - wr0), 64'd2);
    check("ovf_mem30", mem[30], 32'h11111111);
    check("ovf_mem31", mem[31], 32'h22222222);
    @(negedge clock);
    #1;
    check("ovf_rv_one", result_valid, 1'b0);
    check("ovf_go_idle", go, 1'b0);
    check("ovf_rdy_idle", in_ready, 1'b1);

    // Reset during LOAD, while the second beat is presented.
    @(negedge clock);
    start_addr = 5'd5;
    in_valid   = 1'b1;
    in_data    = 32'h1;
    in_last    = 1'b0;
    @(negedge clock);
    in_data = 32'h2;
    #1 check("rl_base_pre", base, 5'd5);
    #1 reset = 1'b0;
    #1;
    check("rl_go", go, 1'b0);
    check("rl_base", base, 5'd0);
    check("rl_len", result_len, 6'd0);
    check("rl_wr_en", rf_wr_en, 1'b0);
    check("rl_rv", result_valid, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1 check("rl_rdy", in_ready, 1'b1);

    // Reset during RUN.
    @(negedge clock);
    start_addr = 5'd9;
    in_valid   = 1'b1;
    in_data    = 32'h5;
    in_last    = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1 check("rr_go_pre", go, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("rr_go", go, 1'b0);
    check("rr_base", base, 5'd0);
    check("rr_ending", ending, 5'd0);
    check("rr_rv", result_valid, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("rr_rdy", in_ready, 1'b1);

    pk = '{32'h7, 32'h8, 32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_pkt("post_rst", 5'd0, 3, pk, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
